// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and IF/ID register with stall, redirect-with-flush and halt on a sentinel word
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = 16'hFFFF,
  parameter logic [15:0] NOP_WORD  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic [15:0] imem_instruction,
  output logic [15:0] imem_address,
  output logic [15:0] if_id_instruction,
  output logic [15:0] if_id_pc_plus2,
  output logic        if_id_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t state, state_next;
  logic [15:0] pc, pc_next, pc_inc, instr_next, pc2_next, count_next;
  logic        valid_next, fire, is_halt, squash;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else     state <= state_next;
  always_comb
    state_next = branch_taken ? RUN : (fire && is_halt) ? HALTED : state;
  always_comb
    halted = state == HALTED;
  assign pc_inc  = pc + 16'd2;
  assign is_halt = imem_instruction == HALT_WORD;
  assign fire    = state == RUN && !stall && !branch_taken;
  // a halted stage flushes IF/ID every edge, exactly like a redirect
  assign squash  = branch_taken || state == HALTED;
  always_comb begin
    pc_next    = branch_taken ? {branch_target[15:1], 1'b0} : (fire && !is_halt) ? pc_inc : pc;
    instr_next = squash ? NOP_WORD : fire ? imem_instruction : if_id_instruction;
    valid_next = squash ? 1'b0 : fire ? 1'b1 : if_id_valid;
    pc2_next   = fire ? pc_inc : if_id_pc_plus2;
    count_next = fire ? fetch_count + 16'd1 : fetch_count;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc                <= {RESET_PC[15:1], 1'b0};
      if_id_instruction <= NOP_WORD;
      if_id_pc_plus2    <= '0;
      if_id_valid       <= 1'b0;
      fetch_count       <= '0;
    end else begin
      pc                <= pc_next;
      if_id_instruction <= instr_next;
      if_id_pc_plus2    <= pc2_next;
      if_id_valid       <= valid_next;
      fetch_count       <= count_next;
    end
  assign imem_address = pc;
endmodule
